bias_add_instr_arbiter: RTL

//   Shares one bias-add custom-instruction slave (BA_XWR/BWR/START/CRD/STAT, opcode 0x33, funct7 0x04)

---
 rtl/bias_add_instr_arbiter_pkg.sv | 26 ++
 rtl/bias_add_instr_arbiter_rr_pick.sv | 30 +++
 rtl/bias_add_instr_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bias_add_instr_arbiter_pkg.sv
// Shared constants, state type and decode helper for the bias-add
// instruction arbiter.
package bias_add_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'h33;
    localparam logic [6:0] F7_BIAS   = 7'h04;
    localparam logic [2:0] F3_XWR    = 3'd0;
    localparam logic [2:0] F3_BWR    = 3'd1;
    localparam logic [2:0] F3_START  = 3'd2;
    localparam logic [2:0] F3_CRD    = 3'd3;
    localparam logic [2:0] F3_STAT   = 3'd4;

    typedef enum logic {
        S_IDLE,
        S_WAIT_RESP
    } arb_state_t;

    // Only CRD and STAT return data through rd
    function automatic logic needs_wb(input logic [31:0] instr);
        return (instr[6:0] == OPC_RTYPE) &&
               (instr[31:25] == F7_BIAS) &&
               ((instr[14:12] == F3_CRD) ||
                (instr[14:12] == F3_STAT));
    endfunction

endpackage

// File: rtl/bias_add_instr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int REQ_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [REQ_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [REQ_W-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = REQ_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bias_add_instr_arbiter.sv
// Round-robin arbiter sharing one bias-add instruction slave among NREQ
// requesters, holding the grant until a CRD/STAT writeback returns.
module bias_add_instr_arbiter
    import bias_add_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int REQ_W       = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TMO_W       = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_instr,
    input  logic [NREQ-1:0][31:0] req_rs1,
    input  logic [NREQ-1:0][31:0] req_rs2,
    input  logic [NREQ-1:0][4:0]  req_rd,
    output logic [NREQ-1:0]       resp_we,
    output logic [4:0]            resp_waddr,
    output logic [31:0]           resp_wdata,
    output logic                  m_instr_valid,
    input  logic                  m_instr_ready,
    output logic [31:0]           m_instr,
    output logic [31:0]           m_rs1_val,
    output logic [31:0]           m_rs2_val,
    output logic [4:0]            m_rd_addr,
    input  logic                  m_rd_we,
    input  logic [4:0]            m_rd_waddr,
    input  logic [31:0]           m_rd_wdata,
    output logic                  err_timeout,
    output logic [REQ_W-1:0]      owner
);

    arb_state_t       state;
    logic [REQ_W-1:0] rr_ptr;
    logic [REQ_W-1:0] lock_idx;
    logic [REQ_W-1:0] pick_idx;
    logic [REQ_W-1:0] g;
    logic [NREQ-1:0]  pick_gnt;
    logic [NREQ-1:0]  g_oh;
    logic             locked;
    logic [TMO_W-1:0] tmo_cnt;
    logic             idle;
    logic             fire;
    logic             tmo_hit;

    rr_pick #(
        .NREQ (NREQ),
        .REQ_W(REQ_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (pick_gnt),
        .gnt_idx(pick_idx)
    );

    // A stalled offer keeps its grant so the slave sees a stable word
    always_comb begin
        g    = locked ? lock_idx : pick_idx;
        g_oh = locked ? (NREQ'(1) << lock_idx) : pick_gnt;
    end

    assign idle          = (state == S_IDLE) && !rst;
    assign m_instr_valid = idle && (|req_valid);
    assign req_ready     = (idle && m_instr_ready) ? g_oh : '0;
    assign fire          = m_instr_valid && m_instr_ready;

    assign m_instr   = req_instr[g];
    assign m_rs1_val = req_rs1[g];
    assign m_rs2_val = req_rs2[g];
    assign m_rd_addr = req_rd[g];

    assign tmo_hit = (TIMEOUT_CYC != 0) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            resp_we     <= '0;
            resp_waddr  <= '0;
            resp_wdata  <= '0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
            locked      <= 1'b0;
            lock_idx    <= '0;
        end else begin
            resp_we     <= '0;
            err_timeout <= 1'b0;
            locked      <= m_instr_valid && !m_instr_ready;
            lock_idx    <= g;
            unique case (state)
                S_IDLE: begin
                    if (fire) begin
                        owner  <= g;
                        rr_ptr <= (g == REQ_W'(NREQ - 1)) ? '0 : g + 1'b1;
                        if (needs_wb(m_instr)) begin
                            state   <= S_WAIT_RESP;
                            tmo_cnt <= '0;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (m_rd_we) begin
                        resp_we    <= NREQ'(1) << owner;
                        resp_waddr <= m_rd_waddr;
                        resp_wdata <= m_rd_wdata;
                        state      <= S_IDLE;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
